// File: rtl/adpcm_mc_decoder.sv
// Multi-channel Dialogic/OKI 4-bit ADPCM decoder: one nibble per 4 clocks, per-channel state.
// Optional per-channel clear ports are enabled by defining ADPCM_CH_CLEAR_EN.
module adpcm_mc_decoder #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = 4,
    parameter int unsigned OUT_W    = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [3:0]              in_code,
`ifdef ADPCM_CH_CLEAR_EN
    input  logic                    clr_valid,
    input  logic [CH_W-1:0]         clr_ch,
`endif
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] sample
);

    // State arrays span the full select range; slots at or above CHANNELS are never written.
    localparam int unsigned Slots = 2 ** CH_W;
    localparam logic [CH_W:0] ChLimit = (CH_W + 1)'(CHANNELS);

    localparam logic [10:0] StepTab [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
        11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
        11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
        11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
        11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
        11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
        11'd1552
    };

    typedef enum logic [1:0] {StIdle, StLook, StDiff, StUpd} state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         ch_q;
    logic [3:0]              code_q;
    logic [10:0]             ss_q;
    logic [11:0]             d_q;
    logic signed [11:0]      x_q   [Slots];
    logic [5:0]              idx_q [Slots];

    logic                    ch_ok;
    logic [11:0]             d_calc;
    logic signed [11:0]      x_cur;
    logic signed [13:0]      x_sum;
    logic signed [11:0]      x_new;
    logic signed [7:0]       idx_sum;
    logic [5:0]              idx_new;

    function automatic logic signed [4:0] delta(input logic [2:0] mag);
        case (mag)
            3'd4:    return 5'sd2;
            3'd5:    return 5'sd4;
            3'd6:    return 5'sd6;
            3'd7:    return 5'sd8;
            default: return -5'sd1;
        endcase
    endfunction

    assign ch_ok = {1'b0, ch_q} < ChLimit;

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == StIdle);
        unique case (state_q)
            StIdle: if (in_valid) state_d = StLook;
            StLook: state_d = StDiff;
            StDiff: state_d = StUpd;
            StUpd:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        d_calc = (code_q[2] ? 12'(ss_q)      : 12'd0)
               + (code_q[1] ? 12'(ss_q >> 1) : 12'd0)
               + (code_q[0] ? 12'(ss_q >> 2) : 12'd0)
               + 12'(ss_q >> 3);

        // 14 bits so that X + d (up to 2047 + 2910) cannot wrap before the clamp.
        x_cur = x_q[ch_q];
        x_sum = code_q[3] ? 14'(x_cur) - $signed({2'b00, d_q})
                          : 14'(x_cur) + $signed({2'b00, d_q});
        if (x_sum > 14'sd2047)       x_new = 12'sd2047;
        else if (x_sum < -14'sd2048) x_new = -12'sd2048;
        else                         x_new = x_sum[11:0];

        idx_sum = $signed({2'b00, idx_q[ch_q]}) + 8'(delta(code_q[2:0]));
        if (idx_sum < 8'sd0)       idx_new = 6'd0;
        else if (idx_sum > 8'sd48) idx_new = 6'd48;
        else                       idx_new = idx_sum[5:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            code_q    <= '0;
            ss_q      <= '0;
            d_q       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            sample    <= '0;
            for (int i = 0; i < Slots; i++) begin
                x_q[i]   <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            unique case (state_q)
                StIdle: if (in_valid) begin
                    ch_q   <= in_ch;
                    code_q <= in_code;
                end
                StLook: ss_q <= StepTab[idx_q[ch_q]];
                StDiff: d_q  <= d_calc;
                StUpd: if (ch_ok) begin
                    x_q[ch_q]   <= x_new;
                    idx_q[ch_q] <= idx_new;
                    out_valid   <= 1'b1;
                    out_ch      <= ch_q;
                    sample      <= OUT_W'(x_new) <<< (OUT_W - 12);
                end
                default: ;
            endcase
`ifdef ADPCM_CH_CLEAR_EN
            // Placed last so a clear wins over a same-cycle update of that channel.
            if (clr_valid && ({1'b0, clr_ch} < ChLimit)) begin
                x_q[clr_ch]   <= '0;
                idx_q[clr_ch] <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_adpcm_mc_decoder.sv
// Directed bench for adpcm_mc_decoder; a 12-bit and a 16-bit instance share all inputs.
module tb_adpcm_mc_decoder;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [3:0]        in_ch = '0;
    logic [3:0]        in_code = '0;
    logic              in_ready, in_ready16;
    logic              out_valid, out_valid16;
    logic [3:0]        out_ch, out_ch16;
    logic signed [11:0] sample;
    logic signed [15:0] sample16;

    int total = 0;
    int bad   = 0;

    // Observations filled by send.
    logic              got, rdy_at, ov_next, ov16_at;
    int                lat, busy_rdy;
    logic [3:0]        och;
    logic signed [11:0] s12;
    logic signed [15:0] s16;

    always #5 clock = ~clock;

    adpcm_mc_decoder #(.CHANNELS(2), .CH_W(4), .OUT_W(12)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_code(in_code),
`ifdef ADPCM_CH_CLEAR_EN
        .clr_valid(1'b0), .clr_ch(4'd0),
`endif
        .out_valid(out_valid), .out_ch(out_ch), .sample(sample)
    );

    adpcm_mc_decoder #(.CHANNELS(2), .CH_W(4), .OUT_W(16)) dut16 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .in_ch(in_ch), .in_code(in_code),
`ifdef ADPCM_CH_CLEAR_EN
        .clr_valid(1'b0), .clr_ch(4'd0),
`endif
        .out_valid(out_valid16), .out_ch(out_ch16), .sample(sample16)
    );

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Offer one nibble (caller is idle, #1 after an edge) and wait a bounded time for the pulse.
    task automatic send(input logic [3:0] ch, input logic [3:0] code);
        got = 0; lat = 0; busy_rdy = 0; rdy_at = 0; ov_next = 0; ov16_at = 0;
        och = '0; s12 = '0; s16 = '0;
        in_valid = 1'b1; in_ch = ch; in_code = code;
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (in_ready) busy_rdy++;
        for (int i = 1; i <= 8; i++) begin
            if (!got) begin
                @(posedge clock); #1;
                if (out_valid) begin
                    got = 1; lat = i; rdy_at = in_ready; ov16_at = out_valid16;
                    och = out_ch; s12 = sample; s16 = sample16;
                end else if (in_ready) begin
                    busy_rdy++;
                end
            end
        end
        if (got) begin
            @(posedge clock); #1;
            ov_next = out_valid;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sample !== 12'sd0 || out_ch !== 4'd0 ||
            sample16 !== 16'sd0) begin
            bad++;
            $display("FAIL reset_state ready=%b ov=%b sample=%0d ch=%0d s16=%0d want 1/0/0/0/0",
                     in_ready, out_valid, sample, out_ch, sample16);
        end
    endtask

    task automatic test_first_nibbles();
        do_reset();
        send(4'd0, 4'h7);
        total++;
        if (got !== 1'b1 || lat != 3 || busy_rdy != 0 || rdy_at !== 1'b1 || ov_next !== 1'b0) begin
            bad++;
            $display("FAIL timing got=%b lat=%0d busy_rdy=%0d rdy_at=%b ov_next=%b want 1/3/0/1/0",
                     got, lat, busy_rdy, rdy_at, ov_next);
        end
        total++;
        if (och !== 4'd0 || s12 !== 12'sd30 || s16 !== 16'sd480 || ov16_at !== 1'b1) begin
            bad++;
            $display("FAIL first_7 ch=%0d sample=%0d s16=%0d ov16=%b want 0/30/480/1",
                     och, s12, s16, ov16_at);
        end
        send(4'd0, 4'h7);
        total++;
        if (s12 !== 12'sd93 || s16 !== 16'sd1488) begin
            bad++;
            $display("FAIL second_7 sample=%0d s16=%0d want 93/1488", s12, s16);
        end
    endtask

    task automatic test_channels();
        do_reset();
        send(4'd1, 4'hF);
        total++;
        if (got !== 1'b1 || och !== 4'd1 || s12 !== -12'sd30) begin
            bad++;
            $display("FAIL ch1_F got=%b ch=%0d sample=%0d want 1/1/-30", got, och, s12);
        end
        send(4'd0, 4'h7);
        total++;
        if (och !== 4'd0 || s12 !== 12'sd30) begin
            bad++;
            $display("FAIL ch0_indep ch=%0d sample=%0d want 0/30", och, s12);
        end
    endtask

    task automatic test_small_steps();
        logic signed [11:0] want;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            send(4'd0, 4'h0);
            want = 12'(2 * i);
            total++;
            if (s12 !== want) begin
                bad++;
                $display("FAIL code0_%0d sample=%0d want %0d", i, s12, want);
            end
        end
        // Index must have stayed at 0, so the next step is still 16 (d=30).
        send(4'd0, 4'h7);
        total++;
        if (s12 !== 12'sd36) begin
            bad++;
            $display("FAIL idx_floor sample=%0d want 36", s12);
        end
    endtask

    task automatic test_saturate();
        logic signed [11:0] tab [6];
        logic signed [11:0] want;
        tab = '{12'sd30, 12'sd93, 12'sd229, 12'sd522, 12'sd1153, 12'sd2047};
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(4'd0, 4'h7);
            want = (i < 6) ? tab[i] : 12'sd2047;
            total++;
            if (s12 !== want) begin
                bad++;
                $display("FAIL sat_up_%0d sample=%0d want %0d", i, s12, want);
            end
        end
        send(4'd0, 4'hF);
        total++;
        if (s12 !== -12'sd863 || s16 !== -16'sd13808) begin
            bad++;
            $display("FAIL big_neg sample=%0d s16=%0d want -863/-13808", s12, s16);
        end
        send(4'd0, 4'hF);
        total++;
        if (s12 !== -12'sd2048 || s16 !== -16'sd32768) begin
            bad++;
            $display("FAIL sat_down sample=%0d s16=%0d want -2048/-32768", s12, s16);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        send(4'd0, 4'h7);
        send(4'd3, 4'h7);
        total++;
        if (got !== 1'b0 || in_ready !== 1'b1 || sample !== 12'sd30 || out_ch !== 4'd0) begin
            bad++;
            $display("FAIL oob_ch got=%b ready=%b sample=%0d ch=%0d want 0/1/30/0",
                     got, in_ready, sample, out_ch);
        end
        send(4'd1, 4'h7);
        total++;
        if (got !== 1'b1 || och !== 4'd1 || s12 !== 12'sd30) begin
            bad++;
            $display("FAIL after_oob got=%b ch=%0d sample=%0d want 1/1/30", got, och, s12);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        in_valid = 1'b1; in_ch = 4'd0; in_code = 4'h7;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        pulses = 0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready16 !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset ready=%b ov=%b ready16=%b want 1/0/1",
                     in_ready, out_valid, in_ready16);
        end
        repeat (5) begin
            @(posedge clock); #1;
            if (out_valid || out_valid16) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL mid_reset_pulse pulses=%0d want 0", pulses);
        end
        send(4'd0, 4'h7);
        total++;
        if (s12 !== 12'sd30 || s16 !== 16'sd480) begin
            bad++;
            $display("FAIL after_mid_reset sample=%0d s16=%0d want 30/480", s12, s16);
        end
    endtask

    initial begin
        test_reset();
        test_first_nibbles();
        test_channels();
        test_small_steps();
        test_saturate();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
